bpug_seq: RTL

BPUG_SEQ -- requirements
Module: bpug_seq

---
 rtl/bpug_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bpug_seq.sv
// ============================================================================
// Module   : bpug_seq
// Purpose  : Job sequencer that streams weight and image bytes into a BPUG
//            and issues its compute/update instructions row by row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpug_seq #(
    parameter int WGT_BEATS = 7,
    parameter int OUT_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  rows,
    input  logic [4:0]  op,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [12:0] instruction,
    output logic [7:0]  data_out,
    output logic        bpug_en,
    output logic        bpug_sel,
    output logic        busy,
    output logic        out_valid,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDW  = 3'd1,
        S_LDI  = 3'd2,
        S_CMP0 = 3'd3,
        S_CMP1 = 3'd4,
        S_UP   = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [5:0] WGT_BEATS_W = 6'(WGT_BEATS);
    localparam logic [5:0] LDW_LAST    = 6'(8 * WGT_BEATS - 1);

    state_t              state_q, state_d;
    logic [5:0]          beat_q, beat_d;
    logic [3:0]          rows_q, rows_d;
    logic [4:0]          op_q, op_d;
    logic                first_q, first_d;
    logic [OUT_LAT-1:0]  vld_sr_q, vld_sr_d;
    logic [12:0]         instr_q, instr_d;
    logic [7:0]          data_q, data_d;
    logic                en_q, en_d;
    logic                sel_q, sel_d;
    logic                ov_q, ov_d;
    logic                done_q, done_d;
    logic                accept;
    logic                push;
    logic [2:0]          wgt_sel;

    assign s_ready = (state_q == S_LDW) || (state_q == S_LDI);
    assign busy    = (state_q != S_IDLE);
    assign accept  = s_valid && s_ready;
    assign wgt_sel = 3'(beat_q / WGT_BEATS_W);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        rows_d  = rows_q;
        op_d    = op_q;
        first_d = first_q;
        instr_d = '0;
        data_d  = '0;
        en_d    = 1'b0;
        sel_d   = 1'b0;
        done_d  = 1'b0;
        push    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rows != 4'd0) begin
                        rows_d  = rows;
                        op_d    = op;
                        first_d = 1'b1;
                        state_d = S_LDW;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LDW: begin
                if (accept) begin
                    en_d    = 1'b1;
                    data_d  = s_data;
                    instr_d = {wgt_sel, 2'b00, 2'b01, 1'b0, 5'd0};
                    if (beat_q == LDW_LAST) state_d = S_LDI;
                    else                    beat_d  = beat_q + 6'd1;
                end
            end
            S_LDI: begin
                if (accept) begin
                    en_d    = 1'b1;
                    sel_d   = 1'b1;
                    data_d  = s_data;
                    // Only the first pass fills the second image register.
                    instr_d = {3'd0, first_q & beat_q[3], 1'b0, 2'b10, 1'b0, 5'd0};
                    if (beat_q == (first_q ? 6'd15 : 6'd7)) begin
                        state_d = S_CMP0;
                        first_d = 1'b0;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            S_CMP0: begin
                en_d    = 1'b1;
                instr_d = {8'd0, op_q};
                push    = 1'b1;
                state_d = S_CMP1;
            end
            S_CMP1: begin
                en_d    = 1'b1;
                instr_d = {7'd0, 1'b1, op_q};
                push    = 1'b1;
                rows_d  = (rows_q != 4'd0) ? rows_q - 4'd1 : 4'd0;
                state_d = (rows_q > 4'd1) ? S_UP : S_FIN;
            end
            S_UP: begin
                en_d    = 1'b1;
                instr_d = 13'h0100;
                state_d = S_LDI;
            end
            S_FIN: begin
                // Done follows the final out_valid by one cycle.
                if (vld_sr_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) beat_d = 6'd0;

        vld_sr_d    = vld_sr_q << 1;
        vld_sr_d[0] = push;
        ov_d        = vld_sr_q[OUT_LAT-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            rows_q   <= '0;
            op_q     <= '0;
            first_q  <= 1'b0;
            vld_sr_q <= '0;
            instr_q  <= '0;
            data_q   <= '0;
            en_q     <= 1'b0;
            sel_q    <= 1'b0;
            ov_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rows_q   <= rows_d;
            op_q     <= op_d;
            first_q  <= first_d;
            vld_sr_q <= vld_sr_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            en_q     <= en_d;
            sel_q    <= sel_d;
            ov_q     <= ov_d;
            done_q   <= done_d;
        end
    end

    assign instruction = instr_q;
    assign data_out    = data_q;
    assign bpug_en     = en_q;
    assign bpug_sel    = sel_q;
    assign out_valid   = ov_q;
    assign done        = done_q;

endmodule

`default_nettype wire
